// File: rtl/sdram_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler and the SDRAM controller /
// user-FIFO side. The master modport is the scheduler itself.
interface sdram_frame_scheduler_if;
    logic        init_done;
    logic        frame_valid;
    logic [9:0]  wr_fifo_cnt;
    logic [9:0]  rd_fifo_cnt;
    logic        cmd_ack;
    logic        burst_done;
    logic        sdram_wr_req;
    logic        sdram_rd_req;
    logic [21:0] burst_addr;
    logic [1:0]  wr_bank;
    logic [1:0]  rd_bank;
    logic        frame_write_done;
    logic        frame_read_done;

    modport master (
        input  init_done, frame_valid, wr_fifo_cnt, rd_fifo_cnt, cmd_ack, burst_done,
        output sdram_wr_req, sdram_rd_req, burst_addr, wr_bank, rd_bank,
               frame_write_done, frame_read_done
    );

    modport slave (
        output init_done, frame_valid, wr_fifo_cnt, rd_fifo_cnt, cmd_ack, burst_done,
        input  sdram_wr_req, sdram_rd_req, burst_addr, wr_bank, rd_bank,
               frame_write_done, frame_read_done
    );
endinterface

// File: rtl/sdram_frame_scheduler.sv
// Triple-buffered frame scheduler: arbitrates camera write bursts and display
// read bursts into SDRAM, rotating banks so the reader never sees a partial frame.
module sdram_frame_scheduler #(
    parameter int unsigned BURST_LEN   = 256,
    parameter int unsigned FRAME_WORDS = 130560,
    parameter int unsigned FIFO_DEPTH  = 512,
    parameter int unsigned RD_URGENT   = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    sdram_frame_scheduler_if.master        sched_if
);

    localparam logic [19:0] BURST_W = 20'(BURST_LEN);
    localparam logic [19:0] FRAME_W = 20'(FRAME_WORDS);
    localparam logic [10:0] WR_TH   = 11'(BURST_LEN);
    localparam logic [10:0] RD_TH   = 11'(FIFO_DEPTH - BURST_LEN);
    localparam logic [10:0] URG_TH  = 11'(RD_URGENT);

    typedef enum logic [2:0] {
        IDLE, ARB, WR_REQ, WR_BURST, RD_REQ, RD_BURST
    } state_e;

    state_e      state_q, state_d;
    logic [19:0] wr_ptr_q, wr_ptr_d;
    logic [19:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_bank_q, wr_bank_d;
    logic [1:0]  rd_bank_q, rd_bank_d;
    logic [1:0]  full_bank_q, full_bank_d;
    logic        new_frame_q, new_frame_d;
    logic        last_rd_q, last_rd_d;
    logic        fv_q, fv_d;
    logic [21:0] addr_q, addr_d;
    logic        wr_done_q, wr_done_d;
    logic        rd_done_q, rd_done_d;

    logic        wr_ok, rd_ok, urgent, fv_rise;
    logic [19:0] wr_sum, rd_sum;
    logic [1:0]  bank_step, nxt_wr_bank;

    assign wr_ok   = {1'b0, sched_if.wr_fifo_cnt} >= WR_TH;
    assign rd_ok   = {1'b0, sched_if.rd_fifo_cnt} <= RD_TH;
    assign urgent  = {1'b0, sched_if.rd_fifo_cnt} <  URG_TH;
    assign fv_rise = sched_if.frame_valid & ~fv_q;
    assign wr_sum  = wr_ptr_q + BURST_W;
    assign rd_sum  = rd_ptr_q + BURST_W;

    // Next write bank in 0->1->2->0 order, skipping the bank being displayed.
    always_comb begin
        bank_step   = (wr_bank_q == 2'd2) ? 2'd0 : wr_bank_q + 2'd1;
        nxt_wr_bank = bank_step;
        if (bank_step == rd_bank_q) begin
            nxt_wr_bank = (bank_step == 2'd2) ? 2'd0 : bank_step + 2'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_bank_d = full_bank_q;
        new_frame_d = new_frame_q;
        last_rd_d   = last_rd_q;
        fv_d        = sched_if.frame_valid;
        wr_done_d   = 1'b0;
        rd_done_d   = 1'b0;
        addr_d      = '0;

        case (state_q)
            IDLE: begin
                if (sched_if.init_done) state_d = ARB;
            end
            ARB: begin
                if (urgent && rd_ok) begin
                    state_d   = RD_REQ;
                    last_rd_d = 1'b1;
                end else if (wr_ok && rd_ok) begin
                    state_d   = last_rd_q ? WR_REQ : RD_REQ;
                    last_rd_d = ~last_rd_q;
                end else if (wr_ok) begin
                    state_d   = WR_REQ;
                    last_rd_d = 1'b0;
                end else if (rd_ok) begin
                    state_d   = RD_REQ;
                    last_rd_d = 1'b1;
                end
            end
            WR_REQ: begin
                if (sched_if.cmd_ack) state_d = WR_BURST;
            end
            RD_REQ: begin
                if (sched_if.cmd_ack) state_d = RD_BURST;
            end
            WR_BURST: begin
                if (sched_if.burst_done) begin
                    state_d = ARB;
                    // A coincident frame restart discards the completion.
                    if (!fv_rise) begin
                        if (wr_sum == FRAME_W) begin
                            wr_ptr_d    = '0;
                            wr_done_d   = 1'b1;
                            full_bank_d = wr_bank_q;
                            new_frame_d = 1'b1;
                            wr_bank_d   = nxt_wr_bank;
                        end else begin
                            wr_ptr_d = wr_sum;
                        end
                    end
                end
            end
            RD_BURST: begin
                if (sched_if.burst_done) begin
                    state_d = ARB;
                    if (rd_sum == FRAME_W) begin
                        rd_ptr_d  = '0;
                        rd_done_d = 1'b1;
                        if (new_frame_q) begin
                            rd_bank_d   = full_bank_q;
                            new_frame_d = 1'b0;
                        end
                    end else begin
                        rd_ptr_d = rd_sum;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (fv_rise) wr_ptr_d = '0;

        // Address is captured on grant and held, so a frame restart while a
        // request is pending cannot disturb it before cmd_ack.
        case (state_d)
            WR_REQ:  addr_d = (state_q == WR_REQ) ? addr_q : {wr_bank_d, wr_ptr_d};
            RD_REQ:  addr_d = (state_q == RD_REQ) ? addr_q : {rd_bank_d, rd_ptr_d};
            default: addr_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_bank_q   <= 2'd1;
            rd_bank_q   <= 2'd0;
            full_bank_q <= 2'd0;
            new_frame_q <= 1'b0;
            last_rd_q   <= 1'b1;
            fv_q        <= 1'b0;
            addr_q      <= '0;
            wr_done_q   <= 1'b0;
            rd_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_bank_q <= full_bank_d;
            new_frame_q <= new_frame_d;
            last_rd_q   <= last_rd_d;
            fv_q        <= fv_d;
            addr_q      <= addr_d;
            wr_done_q   <= wr_done_d;
            rd_done_q   <= rd_done_d;
        end
    end

    assign sched_if.sdram_wr_req     = (state_q == WR_REQ);
    assign sched_if.sdram_rd_req     = (state_q == RD_REQ);
    assign sched_if.burst_addr       = addr_q;
    assign sched_if.wr_bank          = wr_bank_q;
    assign sched_if.rd_bank          = rd_bank_q;
    assign sched_if.frame_write_done = wr_done_q;
    assign sched_if.frame_read_done  = rd_done_q;

endmodule

// File: tb/tb_sdram_frame_scheduler.sv
// Randomised and directed bench for sdram_frame_scheduler against a
// transaction-level model of the bank/pointer rules.
module tb_sdram_frame_scheduler;

    localparam int BL = 256;
    localparam int FW = 1024;
    localparam int FD = 512;
    localparam int RU = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_frame_scheduler_if bus ();

    sdram_frame_scheduler #(
        .BURST_LEN  (BL),
        .FRAME_WORDS(FW),
        .FIFO_DEPTH (FD),
        .RD_URGENT  (RU)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sched_if(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_ARB, M_WREQ, M_WBURST, M_RREQ, M_RBURST} mphase_t;
    mphase_t m_phase;
    int m_wptr, m_rptr, m_wbank, m_rbank, m_full;
    bit m_newf, m_last_read, m_fv_prev, m_wdone, m_rdone;

    task automatic model_reset();
        m_phase = M_IDLE; m_wptr = 0; m_rptr = 0; m_wbank = 1; m_rbank = 0;
        m_full = 0; m_newf = 0; m_last_read = 1; m_fv_prev = 0; m_wdone = 0; m_rdone = 0;
    endtask

    task automatic model_step();
        bit rise, wok, rok, urg;
        int s;
        rise = bus.frame_valid && !m_fv_prev;
        m_fv_prev = bus.frame_valid;
        m_wdone = 0;
        m_rdone = 0;
        wok = int'(bus.wr_fifo_cnt) >= BL;
        rok = int'(bus.rd_fifo_cnt) <= FD - BL;
        urg = int'(bus.rd_fifo_cnt) < RU;
        case (m_phase)
            M_IDLE: if (bus.init_done) m_phase = M_ARB;
            M_ARB: begin
                if (urg && rok)      begin m_phase = M_RREQ; m_last_read = 1; end
                else if (wok && rok) begin
                    m_phase = m_last_read ? M_WREQ : M_RREQ;
                    m_last_read = !m_last_read;
                end
                else if (wok)        begin m_phase = M_WREQ; m_last_read = 0; end
                else if (rok)        begin m_phase = M_RREQ; m_last_read = 1; end
            end
            M_WREQ: if (bus.cmd_ack) m_phase = M_WBURST;
            M_RREQ: if (bus.cmd_ack) m_phase = M_RBURST;
            M_WBURST: if (bus.burst_done) begin
                m_phase = M_ARB;
                if (!rise) begin
                    s = m_wptr + BL;
                    if (s == FW) begin
                        m_wptr = 0; m_wdone = 1; m_full = m_wbank; m_newf = 1;
                        m_wbank = (m_wbank + 1) % 3;
                        if (m_wbank == m_rbank) m_wbank = (m_wbank + 1) % 3;
                    end else m_wptr = s;
                end
            end
            M_RBURST: if (bus.burst_done) begin
                m_phase = M_ARB;
                s = m_rptr + BL;
                if (s == FW) begin
                    m_rptr = 0; m_rdone = 1;
                    if (m_newf) begin m_rbank = m_full; m_newf = 0; end
                end else m_rptr = s;
            end
            default: m_phase = M_IDLE;
        endcase
        if (rise) m_wptr = 0;
    endtask

    function automatic int exp_addr();
        if (m_phase == M_WREQ) return m_wbank * 1048576 + m_wptr;
        if (m_phase == M_RREQ) return m_rbank * 1048576 + m_rptr;
        return 0;
    endfunction

    // Compare process: every cycle, 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        chk("wr_req", 32'(bus.sdram_wr_req), 32'(m_phase == M_WREQ));
        chk("rd_req", 32'(bus.sdram_rd_req), 32'(m_phase == M_RREQ));
        chk("burst_addr", 32'(bus.burst_addr), exp_addr());
        chk("wr_bank", 32'(bus.wr_bank), m_wbank);
        chk("rd_bank", 32'(bus.rd_bank), m_rbank);
        chk("frame_write_done", 32'(bus.frame_write_done), 32'(m_wdone));
        chk("frame_read_done", 32'(bus.frame_read_done), 32'(m_rdone));
        chk("req_exclusive", 32'(bus.sdram_wr_req & bus.sdram_rd_req), 0);
        chk("banks_distinct", 32'(bus.wr_bank != bus.rd_bank), 1);
    end

    // ---------------- stimulus helpers ----------------
    int grants[$];
    int wdone_cnt, rdone_cnt;

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.init_done = 0; bus.frame_valid = 0; bus.cmd_ack = 0; bus.burst_done = 0;
        bus.wr_fifo_cnt = '0; bus.rd_fifo_cnt = '0;
        model_reset();
        tick(); tick();
        rst = 1'b0;
    endtask

    // Acts as the SDRAM controller: acks each request at once, completes each burst at once.
    task automatic serve(input int n, input bit fv_on_last);
        int done_n = 0;
        int cyc = 0;
        while (done_n < n && cyc < 200) begin
            bus.cmd_ack    = (m_phase == M_WREQ || m_phase == M_RREQ);
            bus.burst_done = (m_phase == M_WBURST || m_phase == M_RBURST);
            if (bus.burst_done) begin
                done_n++;
                if (fv_on_last && done_n == n) bus.frame_valid = 1'b1;
            end
            if (bus.sdram_wr_req) grants.push_back(0);
            else if (bus.sdram_rd_req) grants.push_back(1);
            tick();
            wdone_cnt += int'(bus.frame_write_done);
            rdone_cnt += int'(bus.frame_read_done);
            cyc++;
        end
        bus.cmd_ack = 0;
        bus.burst_done = 0;
        if (done_n < n) chk("serve_timeout", done_n, n);
    endtask

    task automatic wait_wr_req(input string name);
        int n = 0;
        while (!bus.sdram_wr_req && n < 4) begin tick(); n++; end
        chk(name, 32'(bus.sdram_wr_req), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int reqs, n;
        do_reset();
        chk("rst_wr_bank", 32'(bus.wr_bank), 1);
        chk("rst_rd_bank", 32'(bus.rd_bank), 0);
        chk("rst_addr", 32'(bus.burst_addr), 0);

        // Held out of IDLE while init_done is low.
        bus.wr_fifo_cnt = 10'd300; bus.rd_fifo_cnt = 10'd100;
        reqs = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            reqs += int'(bus.sdram_wr_req | bus.sdram_rd_req);
        end
        chk("no_req_before_init", reqs, 0);
        bus.init_done = 1;
        n = 0;
        while (!bus.sdram_wr_req && n < 3) begin tick(); n++; end
        chk("init_wr_req_within_2", 32'(bus.sdram_wr_req && n <= 2), 1);
        chk("init_addr", 32'(bus.burst_addr), 32'h100000);

        // Fair alternation when neither side is urgent.
        grants.delete();
        serve(4, 0);
        chk("grant_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) chk("grant_alternate", grants[i], i % 2);

        // Urgent read wins over a ready write.
        do_reset();
        bus.wr_fifo_cnt = 10'd300; bus.rd_fifo_cnt = 10'd10; bus.init_done = 1;
        tick(); tick();
        chk("urgent_rd_req", 32'(bus.sdram_rd_req), 1);
        chk("urgent_wr_req", 32'(bus.sdram_wr_req), 0);
        chk("urgent_addr", 32'(bus.burst_addr), 0);

        // Full frame write then read: bank rotation.
        do_reset();
        bus.wr_fifo_cnt = 10'd300; bus.rd_fifo_cnt = 10'd500; bus.init_done = 1;
        wdone_cnt = 0;
        serve(4, 0);
        chk("frame_write_done_once", wdone_cnt, 1);
        chk("wr_bank_after_frame", 32'(bus.wr_bank), 2);
        bus.wr_fifo_cnt = 10'd0; bus.rd_fifo_cnt = 10'd100;
        rdone_cnt = 0;
        serve(4, 0);
        chk("frame_read_done_once", rdone_cnt, 1);
        chk("rd_bank_after_frame", 32'(bus.rd_bank), 1);
        bus.wr_fifo_cnt = 10'd300; bus.rd_fifo_cnt = 10'd500;
        serve(4, 0);
        chk("wr_bank_skips_rd", 32'(bus.wr_bank), 0);

        // frame_valid restart after two bursts, then coincident with a frame end.
        do_reset();
        bus.wr_fifo_cnt = 10'd300; bus.rd_fifo_cnt = 10'd500; bus.init_done = 1;
        serve(2, 0);
        bus.wr_fifo_cnt = 10'd0;
        tick(); tick();
        bus.frame_valid = 1;
        tick();
        bus.wr_fifo_cnt = 10'd300;
        wait_wr_req("fv_wr_req");
        chk("fv_restart_addr", 32'(bus.burst_addr), 32'h100000);
        wdone_cnt = 0;
        serve(3, 0);
        bus.frame_valid = 0;
        serve(1, 1);
        chk("fv_coincident_no_done", wdone_cnt, 0);
        chk("fv_coincident_bank", 32'(bus.wr_bank), 1);
        wait_wr_req("fv2_wr_req");
        chk("fv_coincident_addr", 32'(bus.burst_addr), 32'h100000);

        // Asynchronous reset in the middle of a read burst.
        do_reset();
        bus.wr_fifo_cnt = 10'd0; bus.rd_fifo_cnt = 10'd100; bus.init_done = 1;
        n = 0;
        while (m_phase != M_RBURST && n < 10) begin
            bus.cmd_ack = (m_phase == M_RREQ);
            tick(); n++;
        end
        bus.cmd_ack = 0;
        chk("reached_rd_burst", 32'(m_phase == M_RBURST), 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_rd_req", 32'(bus.sdram_rd_req), 0);
        chk("async_rst_wr_req", 32'(bus.sdram_wr_req), 0);
        chk("async_rst_addr", 32'(bus.burst_addr), 0);
        chk("async_rst_wr_bank", 32'(bus.wr_bank), 1);
        chk("async_rst_rd_bank", 32'(bus.rd_bank), 0);
        tick();
        rst = 1'b0; bus.init_done = 0; bus.burst_done = 1;
        tick();
        bus.burst_done = 0;
        tick();
        chk("post_rst_no_read_done", 32'(bus.frame_read_done), 0);

        // Randomised traffic.
        do_reset();
        bus.init_done = 1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 8 == 0) begin
                bus.wr_fifo_cnt = 10'($urandom_range(0, 1023));
                bus.rd_fifo_cnt = 10'($urandom_range(0, 600));
            end
            bus.cmd_ack    = ($urandom % 3) == 0;
            bus.burst_done = ($urandom % 4) == 0;
            if (bus.frame_valid) begin
                if ($urandom % 20 == 0) bus.frame_valid = 0;
            end else if (m_phase != M_WREQ && $urandom % 40 == 0) begin
                bus.frame_valid = 1;
            end
            tick();
        end
        bus.cmd_ack = 0; bus.burst_done = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
